// File: rtl/ifetch_ctrl.sv
// Instruction-fetch control: single-outstanding req/ack fetch feeding the IF/ID register.
// Define IFETCH_PERF_EN to add the fetch_wait_cnt_o memory-wait cycle counter.
module ifetch_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        pcEnable_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
`ifdef IFETCH_PERF_EN
    output logic [31:0] fetch_wait_cnt_o,
`endif
    output logic        valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic        drop_q;
    logic [31:0] addr_q;
    logic [31:0] hold_q;

    logic        resp_ok;
    logic        hold_ok;
    logic        deliver;
    logic [31:0] deliver_word;

    // A word is usable only if nothing has invalidated it: a pending drop,
    // a flush this cycle, or the CPU being halted.
    assign resp_ok      = (state_q == ST_WAIT) && mem_ack_i && !drop_q && !flush_i && start_i;
    assign hold_ok      = (state_q == ST_HOLD) && !flush_i && start_i;
    assign deliver      = (resp_ok || hold_ok) && !stall_i;
    assign deliver_word = (state_q == ST_HOLD) ? hold_q : mem_data_i;

    assign mem_req_o  = (state_q == ST_WAIT);
    assign mem_addr_o = addr_q;
    assign pcEnable_o = rst_i && start_i && (flush_i || deliver);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            addr_q  <= 32'h0;
            hold_q  <= 32'h0;
            instr_o <= 32'h0;
            pc_o    <= 32'h0;
            valid_o <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        addr_q  <= pc_i;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        drop_q <= 1'b0;
                        if (drop_q || flush_i || !start_i || !stall_i) begin
                            state_q <= ST_IDLE;
                        end else begin
                            hold_q  <= mem_data_i;
                            state_q <= ST_HOLD;
                        end
                    end else if (flush_i || !start_i) begin
                        // Request cannot be withdrawn; remember to discard its response.
                        drop_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush_i || !start_i || !stall_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (flush_i) begin
                instr_o <= 32'h0;
                pc_o    <= 32'h0;
                valid_o <= 1'b0;
            end else if (!stall_i) begin
                if (deliver) begin
                    instr_o <= deliver_word;
                    pc_o    <= addr_q + 32'd4;
                    valid_o <= 1'b1;
                end else begin
                    instr_o <= 32'h0;
                    valid_o <= 1'b0;
                end
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_wait_cnt_o <= 32'h0;
        end else if (state_q == ST_WAIT) begin
            fetch_wait_cnt_o <= fetch_wait_cnt_o + 32'd1;
        end
    end
`endif

endmodule
